// File: rtl/bus_defs_pkg.sv
// Shared bus definitions for the SRAM slave: Control field codes, FSM state type
// and small decode helpers used by the slave datapath.
package bus_defs_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_CONT  = 2'b01,
    ST_IDLE  = 2'b10,
    ST_BUSY  = 2'b11
  } status_t;

  typedef enum logic [3:0] {
    BURST1    = 4'd0,
    BURST2    = 4'd1,
    BURST4    = 4'd2,
    BURST8    = 4'd3,
    BURST16   = 4'd4,
    BURST32   = 4'd5,
    BURST64   = 4'd6,
    BURSTPAGE = 4'd7
  } burst_t;

  typedef enum logic [1:0] {
    SZ_B  = 2'b00,
    SZ_HW = 2'b01,
    SZ_W  = 2'b10,
    SZ_DW = 2'b11
  } size_t;

  localparam logic WE_READ  = 1'b0;
  localparam logic WE_WRITE = 1'b1;

  localparam int BEAT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2
  } state_t;

  // Unused burst codes behave as single transfers.
  function automatic logic [BEAT_W-1:0] burst_len(input logic [3:0] burst,
                                                 input int page_beats);
    case (burst)
      BURST1:    return 16'd1;
      BURST2:    return 16'd2;
      BURST4:    return 16'd4;
      BURST8:    return 16'd8;
      BURST16:   return 16'd16;
      BURST32:   return 16'd32;
      BURST64:   return 16'd64;
      BURSTPAGE: return page_beats[BEAT_W-1:0];
      default:   return 16'd1;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input size_t size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_HW:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input size_t size, input logic [1:0] lo);
    case (size)
      SZ_B:    return 4'b0001 << lo;
      SZ_HW:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [1:0] align_low(input size_t size, input logic [1:0] lo);
    case (size)
      SZ_B:    return lo;
      SZ_HW:   return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input size_t size, input logic [1:0] lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_HW:   return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/bus_sram_slave_if.sv
// System-bus slave port bundle for bus_sram_slave.
// Err exists only when BUS_SRAM_SLAVE_ERR_EN is defined.
interface bus_sram_slave_if;
  // Handshake: Ready=0 is a wait state. A beat completes on the rising edge
  // where Ready=1 while the master drives sel=1 and status CONT; the master
  // holds Address/Control and presents WData for that beat until it completes.
  logic        sel;
  logic [31:0] Address;
  logic [31:0] WData;
  logic [8:0]  Control;
  logic [31:0] RData;
  logic        Ready;
`ifdef BUS_SRAM_SLAVE_ERR_EN
  logic        Err;

  modport master (output sel, Address, WData, Control, input RData, Ready, Err);
  modport slave  (input sel, Address, WData, Control, output RData, Ready, Err);
`else
  modport master (output sel, Address, WData, Control, input RData, Ready);
  modport slave  (input sel, Address, WData, Control, output RData, Ready);
`endif
endinterface

// File: rtl/sram_byte_mem.sv
// Single-port style SRAM, 2**ADDR_W x 32, four byte-write enables and a
// registered read port that is write-first when read and write hit one word.
module sram_byte_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic w_same_word;
  assign w_same_word = (i_waddr == i_raddr);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;
    logic       w_lane_we;

    assign w_lane_we = i_we && i_be[g];

    always_ff @(posedge clk) begin
      if (w_lane_we) begin
        r_mem[i_waddr] <= i_wdata[8*g +: 8];
      end
      if (w_lane_we && w_same_word) begin
        r_q <= i_wdata[8*g +: 8];
      end else begin
        r_q <= r_mem[i_raddr];
      end
    end

    assign o_rdata[8*g +: 8] = r_q;
  end

endmodule

// File: rtl/bus_sram_slave.sv
// On-chip SRAM responder on the system bus with programmable wait states.
// Define BUS_SRAM_SLAVE_ERR_EN to reject DW / misaligned starts with Err.
module bus_sram_slave
  import bus_defs_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1,
  parameter int PAGE_BEATS  = 256
) (
  input  logic            clk,
  input  logic            reset,
  bus_sram_slave_if.slave bus,
  output state_t          o_dbg_state
);

  localparam int         AW        = ADDR_W + 2;
  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            r_state;
  logic              r_ready;
  logic [AW-1:0]     r_addr;
  size_t             r_size;
  logic              r_we;
  logic [BEAT_W-1:0] r_beats;
  logic [3:0]        r_wait;
`ifdef BUS_SRAM_SLAVE_ERR_EN
  logic              r_err;
  logic              w_reject;
`endif

  status_t       w_status;
  logic [3:0]    w_burst;
  size_t         w_size_in;
  size_t         w_start_size;
  logic          w_we_in;
  logic          w_start;
  logic          w_abandon;
  logic          w_beat;
  logic [AW-1:0] w_start_addr;
  logic [AW-1:0] w_addr_inc;
  logic [AW-1:0] w_next_addr;
  logic [3:0]    w_be;
  logic [31:0]   w_lane_bits;
  logic [31:0]   w_mem_q;
  logic          w_mem_we;
  logic          w_unused;

  assign w_status  = status_t'(bus.Control[8:7]);
  assign w_burst   = bus.Control[6:3];
  assign w_size_in = size_t'(bus.Control[2:1]);
  assign w_we_in   = bus.Control[0];

  // DW has no 64-bit datapath here, so it always runs as a word transfer.
  assign w_start_size = (w_size_in == SZ_DW) ? SZ_W : w_size_in;
  assign w_start_addr = {bus.Address[AW-1:2], align_low(w_start_size, bus.Address[1:0])};

  assign w_start   = bus.sel && (w_status == ST_START);
  assign w_abandon = !bus.sel || (w_status == ST_IDLE);
  assign w_beat    = (r_state == S_XFER) && bus.sel && (w_status == ST_CONT);

`ifdef BUS_SRAM_SLAVE_ERR_EN
  assign w_reject = w_start &&
                    ((w_size_in == SZ_DW) || misaligned(w_size_in, bus.Address[1:0]));
`endif

  assign w_addr_inc = r_addr + {{(AW-3){1'b0}}, size_bytes(r_size)};

  // The RAM read port is fed the address r_addr will hold after this edge, so
  // its registered output always matches the beat currently on the bus.
  always_comb begin
    w_next_addr = r_addr;
    if (w_start) begin
      w_next_addr = w_start_addr;
    end else if (w_beat) begin
      w_next_addr = w_addr_inc;
    end
  end

  assign w_be        = lane_mask(r_size, r_addr[1:0]);
  assign w_lane_bits = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  assign w_mem_we    = w_beat && r_we;

  sram_byte_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_be    (w_be),
    .i_waddr (r_addr[AW-1:2]),
    .i_wdata (bus.WData),
    .i_raddr (w_next_addr[AW-1:2]),
    .o_rdata (w_mem_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_addr  <= '0;
      r_size  <= SZ_B;
      r_we    <= WE_READ;
      r_beats <= '0;
      r_wait  <= '0;
`ifdef BUS_SRAM_SLAVE_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
`ifdef BUS_SRAM_SLAVE_ERR_EN
      r_err <= 1'b0;
      if (w_reject) begin
        r_state <= S_IDLE;
        r_ready <= 1'b1;
        r_err   <= 1'b1;
        r_beats <= '0;
      end else
`endif
      if (w_start) begin
        // A new START always wins, even in the middle of another burst.
        r_addr  <= w_start_addr;
        r_size  <= w_start_size;
        r_we    <= w_we_in;
        r_beats <= burst_len(w_burst, PAGE_BEATS);
        if (HAS_WAIT) begin
          r_state <= S_WAIT;
          r_ready <= 1'b0;
          r_wait  <= WAIT_LOAD;
        end else begin
          r_state <= S_XFER;
          r_ready <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_ready <= 1'b1;
          end
          S_WAIT: begin
            if (w_abandon) begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
            end else if (r_wait == 4'd0) begin
              r_state <= S_XFER;
              r_ready <= 1'b1;
            end else begin
              r_wait <= r_wait - 4'd1;
            end
          end
          S_XFER: begin
            if (w_abandon) begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
            end else if (w_beat) begin
              r_addr  <= w_addr_inc;
              r_beats <= r_beats - BEAT_W'(1);
              if (r_beats == BEAT_W'(1)) begin
                r_state <= S_IDLE;
                r_ready <= 1'b1;
              end else if (HAS_WAIT) begin
                r_state <= S_WAIT;
                r_ready <= 1'b0;
                r_wait  <= WAIT_LOAD;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.Ready = r_ready;
  assign bus.RData = ((r_state == S_XFER) && !r_we) ? (w_mem_q & w_lane_bits) : 32'h0;
`ifdef BUS_SRAM_SLAVE_ERR_EN
  assign bus.Err   = r_err;
`endif
  assign o_dbg_state = r_state;

  // Byte-address bits above the memory span are ignored.
  assign w_unused = ^bus.Address[31:AW];

endmodule

// File: tb/tb_bus_sram_slave.sv
// Scoreboard bench for bus_sram_slave: the driver pushes the expected
// {Err, Ready, RData} for every bus cycle, a negedge monitor pops and compares.
module tb_bus_sram_slave;
  import bus_defs_pkg::*;

  localparam int WAIT_CYCLES = 1;
  localparam int EW          = 34;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  bus_sram_slave_if bus ();

  bus_sram_slave #(
    .ADDR_W      (10),
    .WAIT_CYCLES (WAIT_CYCLES),
    .PAGE_BEATS  (256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  string         cur_tag = "reset";
  logic [31:0]   wd_v [16];
  logic [31:0]   rd_v [16];
  logic          act_err;

`ifdef BUS_SRAM_SLAVE_ERR_EN
  assign act_err = bus.Err;
`else
  assign act_err = 1'b0;
`endif

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // monitor
  always @(negedge clk) begin
    logic [EW-1:0] exp_v;
    logic [EW-1:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {act_err, bus.Ready, bus.RData};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s @%0t: got err=%0b rdy=%0b rdata=%h, expected err=%0b rdy=%0b rdata=%h",
                 cur_tag, $time, act_v[33], act_v[32], act_v[31:0],
                 exp_v[33], exp_v[32], exp_v[31:0]);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic s, input status_t st, input logic [31:0] a,
                       input logic [3:0] bc, input size_t sz, input logic we,
                       input logic [31:0] wd);
    bus.sel     = s;
    bus.Address = a;
    bus.Control = {st, bc, sz, we};
    bus.WData   = wd;
  endtask

  task automatic drive_idle();
    drive(1'b0, ST_IDLE, 32'h0, BURST1, SZ_B, 1'b0, 32'h0);
  endtask

  task automatic tick(input logic e, input logic r, input logic [31:0] d);
    exp_q.push_back({e, r, d});
    @(posedge clk);
    #1;
  endtask

  task automatic set_wd4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
    wd_v[0] = a; wd_v[1] = b; wd_v[2] = c; wd_v[3] = d;
  endtask

  task automatic set_rd4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
    rd_v[0] = a; rd_v[1] = b; rd_v[2] = c; rd_v[3] = d;
  endtask

  // One burst: START cycle, then per beat WAIT_CYCLES wait cycles, optional
  // BUSY cycles, and the completing CONT cycle; ends with one idle cycle.
  task automatic burst(input string tag, input logic [31:0] a, input logic [3:0] bc,
                       input size_t sz, input logic we, input int n,
                       input int busy_at, input int busy_len, input int rst_after);
    logic [31:0] rd;
    cur_tag = tag;
    drive(1'b1, ST_START, a, bc, sz, we, 32'h0);
    tick(1'b0, 1'b1, 32'h0);
    for (int k = 0; k < n; k++) begin
      rd = we ? 32'h0 : rd_v[k];
      drive(1'b1, ST_CONT, a, bc, sz, we, wd_v[k]);
      for (int w = 0; w < WAIT_CYCLES; w++) tick(1'b0, 1'b0, 32'h0);
      if (k == busy_at) begin
        drive(1'b1, ST_BUSY, a, bc, sz, we, wd_v[k]);
        for (int b = 0; b < busy_len; b++) tick(1'b0, 1'b1, rd);
        drive(1'b1, ST_CONT, a, bc, sz, we, wd_v[k]);
      end
      tick(1'b0, 1'b1, rd);
      if (k == rst_after) begin
        cur_tag = {tag, "_async_reset"};
        reset = 1'b1;
        tick(1'b0, 1'b1, 32'h0);
        reset = 1'b0;
        break;
      end
    end
    cur_tag = {tag, "_end"};
    drive_idle();
    tick(1'b0, 1'b1, 32'h0);
  endtask

  // stimulus
  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    tick(1'b0, 1'b1, 32'h0);
    reset = 1'b0;
    tick(1'b0, 1'b1, 32'h0);
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, expected %0d", dbg_state, S_IDLE);
    end

    set_wd4(32'h11223344, 32'h22222222, 32'h33333333, 32'h44444444);
    burst("w_burst4_word", 32'h0000_4AD0, BURST4, SZ_W, 1'b1, 4, -1, 0, -1);

    set_rd4(32'h00000044, 32'h00003300, 32'h00220000, 32'h11000000);
    burst("r_burst4_byte", 32'h0000_4AD0, BURST4, SZ_B, 1'b0, 4, -1, 0, -1);

    for (int k = 0; k < 8; k++) wd_v[k] = 32'hA000_B000 + (k << 16) + k;
    burst("w_burst8_hw", 32'h0000_0AD0, BURST8, SZ_HW, 1'b1, 8, -1, 0, -1);
    set_rd4(32'hA001B000, 32'hA003B002, 32'hA005B004, 32'hA007B006);
    burst("r_hw_lanes", 32'h0000_0AD0, BURST4, SZ_W, 1'b0, 4, -1, 0, -1);

    set_wd4(32'h55550001, 32'h55550002, 32'h55550003, 32'h55550004);
    burst("w_busy_beat2", 32'h0000_4AD0, BURST4, SZ_W, 1'b1, 4, 1, 3, -1);
    set_rd4(32'h55550001, 32'h55550002, 32'h55550003, 32'h55550004);
    burst("r_busy_chk", 32'h0000_4AD0, BURST4, SZ_W, 1'b0, 4, -1, 0, -1);

    set_wd4(32'h66660001, 32'h66660002, 32'h66660003, 32'h66660004);
    burst("w_reset_mid", 32'h0000_4AD0, BURST4, SZ_W, 1'b1, 4, -1, 0, 1);
    set_rd4(32'h66660001, 32'h66660002, 32'h55550003, 32'h55550004);
    burst("r_reset_chk", 32'h0000_4AD0, BURST4, SZ_W, 1'b0, 4, -1, 0, -1);

`ifdef BUS_SRAM_SLAVE_ERR_EN
    cur_tag = "dw_reject";
    drive(1'b1, ST_START, 32'h0000_4AD0, BURST1, SZ_DW, 1'b1, 32'h77777777);
    tick(1'b0, 1'b1, 32'h0);
    drive_idle();
    tick(1'b1, 1'b1, 32'h0);
    tick(1'b0, 1'b1, 32'h0);
    rd_v[0] = 32'h66660001;
`else
    wd_v[0] = 32'h77777777;
    burst("w_dw_as_word", 32'h0000_4AD0, BURST1, SZ_DW, 1'b1, 1, -1, 0, -1);
    rd_v[0] = 32'h77777777;
`endif
    burst("r_dw_chk", 32'h0000_4AD0, BURST1, SZ_W, 1'b0, 1, -1, 0, -1);

    wd_v[0] = 32'hC0FFEE01;
    wd_v[1] = 32'hC0FFEE02;
    burst("w_wrap_end", 32'h0000_0FFC, BURST2, SZ_W, 1'b1, 2, -1, 0, -1);
    rd_v[0] = 32'hC0FFEE02;
    burst("r_wrap_zero", 32'h0000_0000, BURST1, SZ_W, 1'b0, 1, -1, 0, -1);

    // final report
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
